// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: sequencer states and
// bus-owner codes.
package mem_arbiter_pkg;

  // Sequencer states; ARB_WAIT is only reachable in the wait-state build.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_ACC  = 2'd2,
    ARB_WAIT = 2'd3
  } arb_state_t;

  // Which requester owns the RAM cycle currently in flight.
  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external RAM between instruction fetch and the
// MEM-stage load/store path. Every RAM cycle runs IDLE -> ADDR -> ACC
// (-> WAIT when MEM_ARB_WAIT_STATE_EN is defined). Data accesses have strict
// priority over fetches. A fetch flushed while in flight still completes on
// the RAM pins but produces no if_done and leaves if_data untouched.
//
// Handshake: a requester raises *_req with its address/data and holds them
// until the matching *_done pulse; *_done is high for exactly one cycle, and
// the request seen during that done cycle is treated as the one just served.
//
// Build option: MEM_ARB_WAIT_STATE_EN adds a second strobe cycle (WAIT)
// after ACC; capture and re-arbitration move to the end of WAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output arb_state_t        dbg_state
);

`ifdef MEM_ARB_WAIT_STATE_EN
  localparam arb_state_t LAST_STATE = ARB_WAIT;
`else
  localparam arb_state_t LAST_STATE = ARB_ACC;
`endif

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  logic       own_we_q;
  logic       flushed_q;

  logic       final_cyc;
  logic       arb_point;
  logic       if_live;
  logic       mem_pend;
  logic       if_pend;
  logic       grant;

  // Last strobe cycle of an access: capture point and second arbitration point.
  assign final_cyc = (state_q == LAST_STATE);
  assign arb_point = (state_q == ARB_IDLE) | final_cyc;

  // A request still asserted while its own access is finishing (or in its
  // done cycle) is the one being served, not a new one. A flush in the final
  // cycle retires the old fetch, so the (redirected) fetch is a new request.
  assign if_live  = final_cyc & (owner_q == OWNER_IF) & ~flushed_q & ~if_flush;
  assign mem_pend = mem_req & ~mem_done & ~(final_cyc & (owner_q == OWNER_MEM));
  assign if_pend  = if_req & ~if_done & ~if_live;
  assign grant    = arb_point & (mem_pend | if_pend);

  assign hold      = mem_req & ~mem_done;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // Next state and RAM strobes; strobes decode from state so reset forces them high.
  always_comb begin
    state_d  = state_q;
    ram_en_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        if (grant) state_d = ARB_ADDR;
      end
      ARB_ADDR: begin
        ram_en_n = 1'b0;
        state_d  = ARB_ACC;
      end
      ARB_ACC: begin
        ram_en_n = 1'b0;
        ram_oe_n = own_we_q;
        ram_we_n = ~own_we_q;
`ifdef MEM_ARB_WAIT_STATE_EN
        state_d  = ARB_WAIT;
`else
        state_d  = grant ? ARB_ADDR : ARB_IDLE;
`endif
      end
`ifdef MEM_ARB_WAIT_STATE_EN
      ARB_WAIT: begin
        ram_en_n = 1'b0;
        ram_oe_n = own_we_q;
        ram_we_n = ~own_we_q;
        state_d  = grant ? ARB_ADDR : ARB_IDLE;
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
  end

  // Owner latch and RAM address/data registers, loaded on each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWNER_IF;
      own_we_q  <= 1'b0;
      flushed_q <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (grant) begin
      flushed_q <= 1'b0;
      if (mem_pend) begin
        owner_q   <= OWNER_MEM;
        own_we_q  <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else begin
        owner_q   <= OWNER_IF;
        own_we_q  <= 1'b0;
        ram_addr  <= if_addr;
      end
    end else if (if_flush && (owner_q == OWNER_IF) && (state_q != ARB_IDLE)) begin
      flushed_q <= 1'b1;
    end
  end

  // Read capture and one-cycle completion pulses at the end of the last strobe cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (final_cyc) begin
        if (owner_q == OWNER_MEM) begin
          mem_done <= 1'b1;
          if (!own_we_q) mem_rdata <= ram_rdata;
        end else if (!flushed_q && !if_flush) begin
          if_done <= 1'b1;
          if_data <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized single and
// contending accesses against a memory-image reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARB_WAIT_STATE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk, rst;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [15:0] if_data, mem_rdata, ram_addr, ram_wdata;
  logic        if_done, mem_done, hold, ram_en_n, ram_oe_n, ram_we_n;
  arb_state_t  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // reference memory image and expected held outputs
  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_ifd, exp_mrd;

  // external RAM model
  logic [15:0] ram_mem [0:65535];
  bit          ram_init = 0;
  logic        poke_en = 0;
  logic [15:0] poke_addr = '0, poke_data = '0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .hold(hold),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .dbg_state(dbg_state)
  );

  function automatic logic [15:0] pat(input int a);
    logic [15:0] t;
    t = 16'(a * 40503);
    return t ^ 16'h5A5A;
  endfunction

  // RAM array: filled once, then written by pokes or by a write strobe
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (poke_en) begin
      ram_mem[poke_addr] <= poke_data;
    end else if (!ram_en_n && !ram_we_n) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
  end

  // RAM read data becomes valid mid-cycle while output-enabled
  always @(negedge clk) begin
    ram_rdata <= (!ram_en_n && !ram_oe_n) ? ram_mem[ram_addr] : 16'h0000;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // write strobe must never fall while the address is changing
  logic        prev_we_n = 1'b1;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    if (prev_we_n && !ram_we_n) check("we_fall_addr_stable", ram_addr, prev_addr);
    prev_we_n <= ram_we_n;
    prev_addr <= ram_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic run_single(input int kind, input logic [15:0] a, input logic [15:0] d, input string tag);
    bit got = 0;
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      mem_req = 1'b1; mem_we = (kind == 2); mem_addr = a; mem_wdata = d;
    end
    for (int c = 1; c <= 12 && !got; c++) begin
      tick();
      if ((kind == 0) ? if_done : mem_done) begin
        got = 1;
        check({tag, "_latency"}, c, LAT);
        if (kind == 0) begin
          exp_ifd = ref_mem[a];
          check({tag, "_if_data"}, if_data, exp_ifd);
          check({tag, "_mem_rdata_kept"}, mem_rdata, exp_mrd);
          if_req = 1'b0;
        end else begin
          if (kind == 1) exp_mrd = ref_mem[a];
          else ref_mem[a] = d;
          check({tag, "_mem_rdata"}, mem_rdata, exp_mrd);
          check({tag, "_if_data_kept"}, if_data, exp_ifd);
          mem_req = 1'b0;
        end
      end
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    check({tag, "_done_one_cycle"}, {if_done, mem_done}, 2'b00);
  endtask

  // data access and fetch requested in the same cycle
  task automatic run_pair(input logic we, input logic [15:0] ma, input logic [15:0] d,
                          input logic [15:0] fa, input string tag);
    int md = 0, fd = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = ma; mem_wdata = d;
    if_req = 1'b1; if_addr = fa;
    #1 check({tag, "_hold_first"}, hold, 1'b1);
    for (int c = 1; c <= 16 && fd == 0; c++) begin
      tick();
      if (mem_req) check({tag, "_hold"}, hold, (c < LAT));
      if (c == LAT) check({tag, "_fetch_addr_phase"}, {dbg_state, ram_addr}, {ARB_ADDR, fa});
      if (mem_done) begin
        md = c;
        if (!we) exp_mrd = ref_mem[ma];
        else ref_mem[ma] = d;
        check({tag, "_mem_rdata"}, mem_rdata, exp_mrd);
        mem_req = 1'b0;
      end
      if (if_done) begin
        fd = c;
        exp_ifd = ref_mem[fa];
        check({tag, "_if_data"}, if_data, exp_ifd);
        if_req = 1'b0;
      end
    end
    check({tag, "_mem_latency"}, md, LAT);
    check({tag, "_if_latency"}, fd, 2 * LAT - 1);
    if_req = 1'b0; mem_req = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    exp_ifd = '0; exp_mrd = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);

    // reset state
    #1;
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
    check("rst_ram_bus", {ram_addr, ram_wdata}, 32'h0);
    check("rst_outputs", {if_data, mem_rdata}, 32'h0);
    check("rst_done_hold", {if_done, mem_done, hold}, 3'b000);
    tick(); tick();
    rst = 1'b1;
    tick();

    poke(16'h0004, 16'h1234);
    poke(16'h8000, 16'hBEEF);
    poke(16'h0010, 16'h4321);
    poke(16'h0020, 16'h1111);
    poke(16'h0030, 16'h2222);

    // isolated fetch
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    check("fetch_addr_state", dbg_state, ARB_ADDR);
    check("fetch_addr_strobes", {ram_en_n, ram_oe_n, ram_we_n, ram_addr}, {3'b011, 16'h0004});
    tick();
    check("fetch_acc_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b001);
    check("fetch_acc_no_done", if_done, 1'b0);
`ifdef MEM_ARB_WAIT_STATE_EN
    tick();
    check("fetch_wait_strobes", {dbg_state, ram_en_n, ram_oe_n, ram_we_n}, {ARB_WAIT, 3'b001});
`endif
    tick();
    check("fetch_done", if_done, 1'b1);
    check("fetch_data", if_data, 16'h1234);
    exp_ifd = 16'h1234;
    if_req = 1'b0;
    tick();
    check("fetch_done_pulse", if_done, 1'b0);

    // load and fetch contend
    run_pair(1'b0, 16'h8000, 16'h0000, 16'h0010, "contend");
    check("contend_load_value", mem_rdata, 16'hBEEF);
    check("contend_fetch_value", if_data, 16'h4321);

    // store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h9000; mem_wdata = 16'h00A5;
    tick();
    check("store_addr_phase", {ram_en_n, ram_oe_n, ram_we_n, ram_addr}, {3'b011, 16'h9000});
    tick();
    check("store_acc_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b010);
    check("store_acc_bus", {ram_addr, ram_wdata}, {16'h9000, 16'h00A5});
`ifdef MEM_ARB_WAIT_STATE_EN
    tick();
    check("store_wait_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b010);
`endif
    tick();
    check("store_done", {mem_done, hold}, 2'b10);
    check("store_rdata_kept", mem_rdata, 16'hBEEF);
    check("store_strobe_released", ram_we_n, 1'b1);
    mem_req = 1'b0;
    ref_mem[16'h9000] = 16'h00A5;
    tick();
    run_single(1, 16'h9000, 16'h0000, "store_readback");
    check("store_readback_value", mem_rdata, 16'h00A5);

    // flush during the final strobe cycle of a fetch
    if_req = 1'b1; if_addr = 16'h0020;
    tick(); tick();
`ifdef MEM_ARB_WAIT_STATE_EN
    tick();
`endif
    if_flush = 1'b1; if_addr = 16'h0030;
    tick();
    if_flush = 1'b0;
    check("flush_no_done", if_done, 1'b0);
    check("flush_data_kept", if_data, exp_ifd);
    check("flush_refetch_addr", {dbg_state, ram_addr}, {ARB_ADDR, 16'h0030});
    begin
      int got_c = 0;
      for (int c = 1; c <= 12 && got_c == 0; c++) begin
        tick();
        if (if_done) got_c = c;
      end
      check("flush_refetch_latency", got_c, LAT - 1);
      check("flush_refetch_data", if_data, 16'h2222);
      exp_ifd = 16'h2222;
    end
    if_req = 1'b0;
    tick();

    // reset in the middle of an access
    if_req = 1'b1; if_addr = 16'h0004;
    tick(); tick();
    check("pre_reset_in_acc", dbg_state, ARB_ACC);
    rst = 1'b0;
    #1;
    check("midrst_state", dbg_state, ARB_IDLE);
    check("midrst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
    check("midrst_bus", {ram_addr, ram_wdata}, 32'h0);
    check("midrst_outputs", {if_data, mem_rdata, if_done, mem_done}, 34'h0);
    if_req = 1'b0;
    exp_ifd = '0; exp_mrd = '0;
    tick();
    rst = 1'b1;
    tick();
    run_single(0, 16'h0004, 16'h0000, "post_reset_fetch");

    // randomized traffic over a small address pool to force reuse
    for (int n = 0; n < 40; n++) begin
      int          op;
      logic [15:0] a, b, d;
      op = $urandom_range(0, 4);
      a  = 16'hC000 + 16'($urandom_range(0, 7));
      b  = 16'hC000 + 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      case (op)
        0: run_single(0, a, d, "rnd_fetch");
        1: run_single(1, a, d, "rnd_load");
        2: run_single(2, a, d, "rnd_store");
        3: run_pair(1'b0, a, d, b, "rnd_pair_load");
        default: run_pair(1'b1, a, d, b, "rnd_pair_store");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
